// File: rtl/mult_pkg.sv
// ============================================================================
// Module      : mult_pkg
// Description : Shared constants, operand mode type and truncation helper
//               for the pipelined multiplier wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int LATENCY_MIN = 2;
    localparam int LATENCY_MAX = 8;
    localparam int MASK_W      = 64;

    // Mode bits that travel alongside each operand pair.
    typedef struct packed {
        logic signed_en;
        logic approx_en;
    } mult_mode_t;

    // Ones in bits [width-1:trunc], zero elsewhere.
    function automatic logic [MASK_W-1:0] trunc_mask(input int width, input int trunc);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (i < width && i >= trunc) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_core.sv
// ============================================================================
// Module      : mult_core
// Description : Combinational WIDTH x WIDTH signed/unsigned multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_core #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_en,
    output logic [2*WIDTH-1:0] p
);

    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;

    // Low 2*WIDTH bits of the extended product equal the exact product in both modes.
    assign w_a_ext = signed_en ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign w_b_ext = signed_en ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign p       = w_a_ext * w_b_ext;

endmodule

`default_nettype wire

// File: rtl/mult_pipe_top.sv
// ============================================================================
// Module      : mult_pipe_top
// Description : Valid/ready pipelined wrapper around mult_core with operand
//               truncation mode and completed-operation counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_pipe_top
    import mult_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 3,
    parameter int TRUNC   = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               signed_en,
    input  logic               approx_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p_out,
    output logic [CNT_W-1:0]   op_count
);

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        mult_mode_t       mode;
    } s0_payload_t;

    localparam logic [WIDTH-1:0] c_trunc_mask = WIDTH'(trunc_mask(WIDTH, TRUNC));

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_latency_check
        $error("mult_pipe_top: LATENCY out of range");
    end

    logic [LATENCY-1:0] r_v;
    logic [LATENCY-1:0] w_rdy;
    s0_payload_t        r_s0;
    s0_payload_t        w_s0_next;
    logic [2*WIDTH-1:0] r_prod [LATENCY-1];
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [2*WIDTH-1:0] w_core_p;

    // A stage may advance if any stage at or after it is empty, or the sink drains.
    always_comb begin
        logic acc;
        acc = out_ready;
        for (int i = LATENCY - 1; i >= 0; i--) begin
            acc      = acc || !r_v[i];
            w_rdy[i] = acc;
        end
    end

    assign w_s0_next.x              = x;
    assign w_s0_next.y              = y;
    assign w_s0_next.mode.signed_en = signed_en;
    assign w_s0_next.mode.approx_en = approx_en;

    assign w_a = r_s0.mode.approx_en ? (r_s0.x & c_trunc_mask) : r_s0.x;
    assign w_b = r_s0.mode.approx_en ? (r_s0.y & c_trunc_mask) : r_s0.y;

    mult_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a        (w_a),
        .b        (w_b),
        .signed_en(r_s0.mode.signed_en),
        .p        (w_core_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v   <= '0;
            r_s0  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < LATENCY - 1; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            if (w_rdy[0]) begin
                r_v[0] <= in_valid;
                if (in_valid) begin
                    r_s0 <= w_s0_next;
                end
            end
            if (w_rdy[1]) begin
                r_v[1] <= r_v[0];
                if (r_v[0]) begin
                    r_prod[0] <= w_core_p;
                end
            end
            // r_prod[i-1] holds the product for stage i.
            for (int i = 2; i < LATENCY; i++) begin
                if (w_rdy[i]) begin
                    r_v[i] <= r_v[i-1];
                    if (r_v[i-1]) begin
                        r_prod[i-1] <= r_prod[i-2];
                    end
                end
            end
            if (r_v[LATENCY-1] && out_ready) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_v[LATENCY-1];
    assign p_out     = r_prod[LATENCY-2];
    assign op_count  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mult_pipe_top.sv
// ============================================================================
// Module      : tb_mult_pipe_top
// Description : Scoreboard bench for mult_pipe_top with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_pipe_top;

    localparam int WIDTH   = 16;
    localparam int LATENCY = 3;
    localparam int TRUNC   = 4;
    localparam int CNT_W   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        signed_en;
    logic        approx_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p_out;
    logic [15:0] op_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    mult_pipe_top #(
        .WIDTH  (WIDTH),
        .LATENCY(LATENCY),
        .TRUNC  (TRUNC),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .y        (y),
        .signed_en(signed_en),
        .approx_en(approx_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p_out    (p_out),
        .op_count (op_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per output transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard_extra: got 0x%08h, expected no output", p_out);
                end else begin
                    check("scoreboard", p_out, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic ap, input logic [31:0] e);
        int k    = 0;
        bit done = 1'b0;
        x = a; y = b; signed_en = s; approx_en = ap; in_valid = 1'b1;
        while (!done && k < 50) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b0;
        check("send_accept", 32'(done), 32'd1);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Called one step after the accepting edge; counts cycles until out_valid.
    task automatic measure_latency(input string name);
        int k = 1;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, 32'(k), 32'(LATENCY));
    endtask

    logic [15:0] tx [7] = '{16'h0003, 16'h0007, 16'h0100, 16'h0000, 16'h8000, 16'h8000, 16'h8000};
    logic [15:0] ty [7] = '{16'h0005, 16'h0009, 16'h0100, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h7FFF};
    logic        ts [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] te [7] = '{32'h0000000F, 32'h0000003F, 32'h00010000, 32'h00000000,
                            32'h40000000, 32'hC0008000, 32'h3FFF8000};
    logic [31:0] bp_exp [5] = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int iter;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; signed_en = 1'b0; approx_en = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_p_out",     p_out,          32'd0);
        check("rst_op_count",  32'(op_count),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Signed exact with latency measurement
        send(16'hFFFD, 16'h0007, 1'b1, 1'b0, 32'hFFFFFFEB);
        measure_latency("latency_first");
        drain();
        check("count_signed", 32'(op_count), 32'd1);

        // Unsigned max then back-to-back small
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001);
        send(16'h0002, 16'h0003, 1'b0, 1'b0, 32'h00000006);
        drain();
        check("count_unsigned", 32'(op_count), 32'd3);

        // Approximation mode
        send(16'h0013, 16'h0025, 1'b0, 1'b1, 32'h00000200);
        send(16'hFFFF, 16'h0011, 1'b1, 1'b1, 32'hFFFFFF00);
        send(16'h000F, 16'h1234, 1'b0, 1'b1, 32'h00000000);
        send(16'h0013, 16'h0025, 1'b0, 1'b0, 32'h000002BF);
        drain();
        check("count_approx", 32'(op_count), 32'd7);

        // Full-throughput stream, in_ready must stay high
        for (int i = 0; i < 7; i++) begin
            x = tx[i]; y = ty[i]; signed_en = ts[i]; approx_en = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            if (in_ready) exp_q.push_back(te[i]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();
        check("count_stream", 32'(op_count), 32'd14);

        // Backpressure: sink stalled while streaming x=1..5, y=10
        out_ready = 1'b0; sent = 0;
        x = 16'd1; y = 16'd10; signed_en = 1'b0; approx_en = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(bp_exp[sent]);
                sent++;
            end
            @(posedge clk); #1;
            x = 16'(sent + 1);
        end
        check("bp_accepts",     32'(sent),      32'd3);
        check("bp_in_ready",    32'(in_ready),  32'd0);
        check("bp_out_valid",   32'(out_valid), 32'd1);
        check("bp_p_out_hold",  p_out,          32'h0000000A);
        check("bp_count_hold",  32'(op_count),  32'd14);

        // Release on a full pipe: accept and drain on the same edge
        out_ready = 1'b1; #1;
        check("full_in_ready", 32'(in_ready), 32'd1);
        iter = 0;
        while (sent < 5 && iter < 20) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(bp_exp[sent]);
                sent++;
            end
            @(posedge clk); #1;
            if (iter == 0) begin
                check("same_edge_count", 32'(op_count), 32'd15);
                check("same_edge_sent",  32'(sent),     32'd4);
            end
            iter++;
            if (sent < 5) x = 16'(sent + 1);
        end
        in_valid = 1'b0;
        drain();
        check("count_bp", 32'(op_count), 32'd19);

        // Reset with three operations in flight
        send(16'd1, 16'd1, 1'b0, 1'b0, 32'd1);
        send(16'd2, 16'd1, 1'b0, 1'b0, 32'd2);
        send(16'd3, 16'd1, 1'b0, 1'b0, 32'd3);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_p_out",     p_out,          32'd0);
        check("midrst_op_count",  32'(op_count),  32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        send(16'd4, 16'd5, 1'b0, 1'b0, 32'd20);
        measure_latency("latency_after_reset");
        drain();
        check("count_after_reset", 32'(op_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_pipe_top.md
Name: mult_pipe_top

Overview:
- Parametrised, pipelined successor to the registered multiplier test wrapper. It wraps an exact or approximate multiplier core between a configurable number of register stages.
- Adds a valid/ready handshake with backpressure, a per-transaction signed/unsigned mode, and a per-transaction approximation mode that truncates operand LSBs.
- Adds a completed-operation counter.
- Sits between the stimulus/characterisation front end and the result sink for error and power evaluation of multiplier variants.

Parameters:
- WIDTH, 16, operand width in bits; the product is 2*WIDTH bits.
- LATENCY, 3, register stages from input acceptance to output; legal range 2..8.
- TRUNC, 4, number of operand LSBs forced to zero when approximation is enabled; legal range 0..WIDTH-1.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept an operand transfer this cycle.
- x  in  WIDTH  operand X.
- y  in  WIDTH  operand Y.
- signed_en  in  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
- approx_en  in  1  1 = zero the TRUNC LSBs of both operands before multiplying; sampled with the operands.
- out_valid  out  1  p_out holds a valid product.
- out_ready  in  1  sink accepts p_out this cycle.
- p_out  out  2*WIDTH  product.
- op_count  out  CNT_W  number of completed output transfers.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst is high:
  - all stage valid bits, stage data registers, p_out and op_count are 0;
  - out_valid is 0;
  - in_ready is 1.
- Reset applied mid-operation discards all in-flight operations immediately, with no output for them.
- Transfer rules: an input transfer occurs on a rising edge with in_valid && in_ready. An output transfer occurs on a rising edge with out_valid && out_ready.
- Pipeline stages: S0..S(LATENCY-1), each holding a valid bit v[i] and data.
  - S0 holds x, y, signed_en and approx_en.
  - S1 holds the product, computed combinationally from S0 through the core.
  - S2 and later stages pass the product through.
  - S(LATENCY-1) drives p_out and out_valid.
- Ready chain:
  - rdy[LATENCY-1] = out_ready || !v[LATENCY-1].
  - rdy[i] = rdy[i+1] || !v[i].
  - in_ready = rdy[0].
  - Stage i loads from stage i-1 when rdy[i] is 1. Its valid bit becomes v[i-1], or in_valid for S0.
  - Bubbles collapse, so there is no lost throughput while any stage is empty.
- Latency: with no stall, an operand accepted at the end of cycle c yields out_valid = 1 during cycle c+LATENCY. Throughput is one operation per cycle.
- Stall: while out_valid && !out_ready, p_out is held stable. Upstream stages fill, and in_ready falls once all LATENCY stages are valid.
- Simultaneous accept and drain on a full pipe: out_ready = 1 makes in_ready = 1 combinationally. Both transfers complete on the same edge.
- Arithmetic:
  - Operand preprocessing: if approx_en, x' = x & ~((1<<TRUNC)-1), and likewise y'; otherwise x' = x, y' = y.
  - Signed mode: p_out = signed(x') * signed(y'), exact 2*WIDTH two's complement.
  - Unsigned mode: p_out = x' * y'. There is no overflow at this width.
  - TRUNC = 0 makes approx_en a no-op.
- Ordering: results leave strictly in acceptance order. Mode bits travel with their operands.
- Data registers load only on a stage advance. p_out is unchanged when out_valid = 0.
- op_count increments by 1 on each output transfer and wraps modulo 2^CNT_W.

Decomposition:
- Shared package mult_pkg:
  - LATENCY_MIN = 2 and LATENCY_MAX = 8;
  - function trunc_mask(width, trunc);
  - typedef of the S0 payload struct {x, y, signed_en, approx_en}.
- One sub-module mult_core: purely combinational WIDTH x WIDTH signed/unsigned multiplier with inputs a, b, signed_en and output p. It is replaceable with approximate core variants using the same interface.

Test Plan (WIDTH=16, LATENCY=3, TRUNC=4):
- Signed exact: x=0xFFFD, y=0x0007, signed_en=1, approx_en=0, out_ready=1 -> p_out=0xFFFFFFEB in cycle c+3, op_count=1.
- Unsigned exact at max: x=0xFFFF, y=0xFFFF, signed_en=0 -> p_out=0xFFFE0001. Back-to-back with x=2, y=3 -> next cycle p_out=0x00000006.
- Approximation: unsigned x=0x0013, y=0x0025, approx_en=1 -> p_out=0x00000200. Signed x=0xFFFF, y=0x0011, approx_en=1 -> p_out=0xFFFFFF00.
- Backpressure: out_ready=0 while streaming 5 ops (x=1..5, y=10):
  - in_ready falls after 3 accepts and p_out stays 0x0000000A;
  - releasing out_ready drains 10, 20, 30, 40, 50 in order with no loss or duplicates;
  - op_count ends at 5.
- Full pipe with out_ready=1: in_ready stays 1, one accept and one drain on the same edge.
- Reset mid-stream: assert rst with 3 ops in flight -> out_valid=0, p_out=0 and op_count=0 without waiting for a clock edge. After release, the first new op appears LATENCY cycles after acceptance.
